jk_seq_driver: RTL

- Drives the J/K inputs of a jkff instance so its Q output follows a loaded bit pattern.
- Reads Q back and counts every mismatch against the expected value.
- Serves as the stimulus-and-check partner of the JK flip-flop: the writer of J/K and the reader of Q.
- Used in lab benches and in on-board self-test of JK-based registers.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_excite_enc.sv | 23 ++
 rtl/jk_seq_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and J/K excitation constants for the JK flip-flop sequence driver.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Encoded as {J,K}.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite_enc.sv
// Combinational J/K excitation: set/reset on the first bit, toggle/hold afterwards.
module jk_excite_enc
  import jk_pkg::*;
(
  input  logic       first,
  input  logic       prev_bit,
  input  logic       cur_bit,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    if (first) begin
      // An absolute set/reset puts the flip-flop in a known state regardless of history.
      jk = cur_bit ? JK_SET : JK_RESET;
    end else if (cur_bit != prev_bit) begin
      jk = JK_TOGGLE;
    end else begin
      jk = JK_HOLD;
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Drives J/K of an external JK flip-flop so Q follows PATTERN, and counts Q mismatches.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN-1:0]   PATTERN,
  output logic             J,
  output logic             K,
  input  logic             Q_FB,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int IDX_W = $clog2(LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  // Handshake: START is a request that is only accepted while in IDLE; BUSY is high
  // from the accepting edge until the edge that also raises the one-cycle DONE pulse.

  state_t           state_q, state_d;
  logic [LEN-1:0]   pat_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       jk_q, jk_d;
  logic             v1_q, e1_q, l1_q;
  logic             v2_q, e2_q, l2_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] err_q;

  logic             accept;
  logic             issue_run;
  logic             last_issue;
  logic             final_cmp;
  logic             mismatch;
  logic             enc_first, enc_prev, enc_cur;
  logic [1:0]       enc_jk;

  jk_excite_enc u_enc (
    .first    (enc_first),
    .prev_bit (enc_prev),
    .cur_bit  (enc_cur),
    .jk       (enc_jk)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue_run  = 1'b0;
    last_issue = 1'b0;
    final_cmp  = v2_q && l2_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        issue_run = 1'b1;
        if (idx_q == LAST_IDX) begin
          last_issue = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (final_cmp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pat_q shifts right once per issued bit, so [0] is the previous target and [1] the current.
  always_comb begin
    enc_first = accept;
    enc_prev  = accept ? 1'b0 : pat_q[0];
    enc_cur   = accept ? PATTERN[0] : pat_q[1];
    jk_d      = (accept || issue_run) ? enc_jk : JK_HOLD;
    mismatch  = v2_q && (Q_FB != e2_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      jk_q    <= JK_HOLD;
      v1_q    <= 1'b0;
      e1_q    <= 1'b0;
      l1_q    <= 1'b0;
      v2_q    <= 1'b0;
      e2_q    <= 1'b0;
      l2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      jk_q    <= jk_d;

      // Stage 1 marks the edge a bit is issued; stage 2 the edge the flip-flop captures it.
      v1_q <= accept || issue_run;
      e1_q <= enc_cur;
      l1_q <= last_issue;
      v2_q <= v1_q;
      e2_q <= e1_q;
      l2_q <= l1_q;

      if (accept) begin
        pat_q <= PATTERN;
        idx_q <= IDX_W'(1);
      end else if (issue_run) begin
        pat_q <= pat_q >> 1;
        idx_q <= idx_q + 1'b1;
      end

      if (accept) begin
        busy_q <= 1'b1;
      end else if (final_cmp) begin
        busy_q <= 1'b0;
      end
      done_q <= final_cmp;

      if (accept) begin
        err_q <= '0;
      end else if (mismatch && (err_q != ERR_MAX)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign J       = jk_q[1];
  assign K       = jk_q[0];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR_CNT = err_q;

endmodule
